alu_seq_datapath: RTL and testbench

Synchronous, parametrised successor to the lab ALU datapath: operands are loaded one at a time over a shared data bus, an operation is launched with `start`, and the result is returned with a one-cycle `alu_done` pulse. All state is held in registers and updated on the clock edge, driven by an explicit FSM. The opcode set is extended with AND, OR, a multi-cycle shift-add multiply, and result chaining. The block sits between the lab stimulus controller and the result checker.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_seq_multiplier.sv | 46 ++++
 rtl/alu_seq_datapath.sv | 127 ++++++++++++
 tb/tb_alu_seq_datapath.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU datapath: opcode and FSM state encodings
// plus the opcode legality helper.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_PAR  = 3'b010,
        OP_COMP = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_MUL  = 3'b110,
        OP_ILL  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL_ITER,
        S_DONE
    } state_e;

    function automatic logic op_is_legal(input opcode_e op);
        return op != OP_ILL;
    endfunction

endpackage

// File: rtl/alu_seq_multiplier.sv
// Unsigned shift-add multiplier: one multiplier bit per step, W steps per product.
module alu_seq_multiplier #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic [2*W-1:0] r_prod;
    logic [CW-1:0]  r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (load) begin
            r_mcand  <= {{W{1'b0}}, a};
            r_mplier <= b;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (step) begin
            if (r_mplier[0])
                r_prod <= r_prod + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Asserted during the final step; the product is complete after that edge.
    assign done    = step && (r_cnt == CW'(W - 1));
    assign product = r_prod;

endmodule

// File: rtl/alu_seq_datapath.sv
// Sequential ALU: operands loaded over a shared bus, op launched by start,
// result/flags registered and flagged with a one-cycle alu_done pulse.
module alu_seq_datapath
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic [2:0]            opcode_value,
    input  logic                  store_a,
    input  logic                  store_b,
    input  logic                  use_result,
    input  logic                  start,
    output logic                  busy,
    output logic                  alu_done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow_def,
    output logic                  error
);

    localparam int W = DATA_WIDTH;

    state_e         r_state, w_next;
    opcode_e        r_op;
    logic [W-1:0]   r_buf_a, r_buf_b, r_opa, r_opb;
    logic [W-1:0]   r_result;
    logic           r_ovf, r_err;

    logic           w_launch, w_mul_load, w_mul_step, w_mul_last;
    logic [W-1:0]   w_opa_sel;
    logic [2*W-1:0] w_product;
    logic [W:0]     w_sum, w_diff;
    logic [W-1:0]   w_res;
    logic           w_ovf;

    assign w_launch   = (r_state == S_IDLE) && start && !store_a && !store_b;
    assign w_opa_sel  = use_result ? r_result : r_buf_a;
    assign w_mul_load = w_launch && (opcode_e'(opcode_value) == OP_MUL);
    assign w_mul_step = (r_state == S_MUL_ITER);

    alu_seq_multiplier #(.W(W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (w_mul_load),
        .step    (w_mul_step),
        .a       (w_opa_sel),
        .b       (r_buf_b),
        .done    (w_mul_last),
        .product (w_product)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // MUL routes through EXEC after its last step so the finished product is
    // captured on the same edge as every other op's result.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_launch)
                            w_next = (opcode_e'(opcode_value) == OP_MUL) ? S_MUL_ITER : S_EXEC;
            S_MUL_ITER: if (w_mul_last) w_next = S_EXEC;
            S_EXEC:     w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    assign w_sum  = {1'b0, r_opa} + {1'b0, r_opb};
    assign w_diff = {1'b0, r_opa} - {1'b0, r_opb};

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (r_op)
            OP_ADD:  begin w_res = w_sum[W-1:0];  w_ovf = w_sum[W];  end
            OP_SUB:  begin w_res = w_diff[W-1:0]; w_ovf = w_diff[W]; end
            OP_PAR:  w_res = {{(W-1){1'b0}}, ^(r_opa ^ r_opb)};
            OP_COMP: w_res = r_opa ~^ r_opb;
            OP_AND:  w_res = r_opa & r_opb;
            OP_OR:   w_res = r_opa | r_opb;
            OP_MUL:  begin w_res = w_product[W-1:0]; w_ovf = |w_product[2*W-1:W]; end
            default: begin w_res = '0; w_ovf = 1'b0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_a  <= '0;
            r_buf_b  <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_op     <= OP_ADD;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (store_a)
                    r_buf_a <= alu_data;
                else if (store_b)
                    r_buf_b <= alu_data;
                else if (start) begin
                    r_op  <= opcode_e'(opcode_value);
                    r_opa <= w_opa_sel;
                    r_opb <= r_buf_b;
                end
            end
            if (r_state == S_EXEC) begin
                r_result <= w_res;
                r_ovf    <= w_ovf;
                r_err    <= !op_is_legal(r_op);
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign alu_done     = (r_state == S_DONE);
    assign result       = r_result;
    assign overflow_def = r_ovf;
    assign error        = r_err;

endmodule

// File: tb/tb_alu_seq_datapath.sv
// Directed self-checking bench for alu_seq_datapath at DATA_WIDTH = 8.
module tb_alu_seq_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] alu_data;
    logic [2:0] opcode_value;
    logic       store_a, store_b, use_result, start;
    logic       busy, alu_done, overflow_def, error;
    logic [7:0] result;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq_datapath #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_data     (alu_data),
        .opcode_value (opcode_value),
        .store_a      (store_a),
        .store_b      (store_b),
        .use_result   (use_result),
        .start        (start),
        .busy         (busy),
        .alu_done     (alu_done),
        .result       (result),
        .overflow_def (overflow_def),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        store_a = 1'b1; alu_data = a; step(); store_a = 1'b0;
        store_b = 1'b1; alu_data = b; step(); store_b = 1'b0;
    endtask

    // Launches an op and stops in the alu_done cycle (or at the cycle bound).
    task automatic launch(input logic [2:0] op, input logic ur, output int lat);
        opcode_value = op; use_result = ur; start = 1'b1;
        step();
        start = 1'b0; use_result = 1'b0;
        lat = 1;
        while (!alu_done && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic ur,
                          input logic [7:0] e_res, input logic e_ovf, input logic e_err,
                          input int e_lat);
        int lat;
        launch(op, ur, lat);
        check({tag, ".latency"}, lat, e_lat);
        check({tag, ".result"}, result, e_res);
        check({tag, ".ovf"}, overflow_def, e_ovf);
        check({tag, ".err"}, error, e_err);
        check({tag, ".busy_at_done"}, busy, 1);
        step();
        check({tag, ".done_pulse"}, alu_done, 0);
        check({tag, ".busy_after"}, busy, 0);
    endtask

    initial begin
        int cnt;
        logic [7:0] seen;
        reset = 1'b1; alu_data = '0; opcode_value = '0;
        store_a = 1'b0; store_b = 1'b0; use_result = 1'b0; start = 1'b0;
        step(); step();
        check("rst.busy", busy, 0);
        check("rst.done", alu_done, 0);
        check("rst.result", result, 0);
        check("rst.ovf", overflow_def, 0);
        check("rst.err", error, 0);
        reset = 1'b0;

        load(8'd200, 8'd100);  run_op("add",  3'b000, 1'b0, 8'd44,   1'b1, 1'b0, 2);
        load(8'd5,   8'd7);    run_op("sub",  3'b001, 1'b0, 8'd254,  1'b1, 1'b0, 2);
        load(8'hF0,  8'hF0);   run_op("comp", 3'b011, 1'b0, 8'hFF,   1'b0, 1'b0, 2);
        load(8'h03,  8'h01);   run_op("par",  3'b010, 1'b0, 8'd1,    1'b0, 1'b0, 2);
        load(8'hCC,  8'hAA);   run_op("and",  3'b100, 1'b0, 8'h88,   1'b0, 1'b0, 2);
        run_op("or",   3'b101, 1'b0, 8'hEE,   1'b0, 1'b0, 2);
        load(8'd15,  8'd17);   run_op("mul1", 3'b110, 1'b0, 8'd255,  1'b0, 1'b0, 10);
        load(8'd16,  8'd16);   run_op("mul2", 3'b110, 1'b0, 8'd0,    1'b1, 1'b0, 10);

        // Chaining: A from result register, buf_a untouched.
        load(8'd3, 8'd4);      run_op("chain0", 3'b000, 1'b0, 8'd7,  1'b0, 1'b0, 2);
        run_op("chain1", 3'b000, 1'b1, 8'd11, 1'b0, 1'b0, 2);
        run_op("chain2", 3'b000, 1'b0, 8'd7,  1'b0, 1'b0, 2);

        // Reset during MUL iteration 4.
        load(8'd5, 8'd7);      run_op("sub2", 3'b001, 1'b0, 8'd254, 1'b1, 1'b0, 2);
        load(8'd15, 8'd17);
        opcode_value = 3'b110; start = 1'b1; step(); start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (alu_done) cnt++;
            step();
        end
        reset = 1'b1; step(); reset = 1'b0;
        check("midrst.no_done", cnt, 0);
        check("midrst.busy", busy, 0);
        check("midrst.done", alu_done, 0);
        check("midrst.result", result, 0);
        check("midrst.ovf", overflow_def, 0);
        check("midrst.err", error, 0);
        load(8'd1, 8'd2);      run_op("postrst", 3'b000, 1'b0, 8'd3, 1'b0, 1'b0, 2);

        load(8'd9, 8'd9);      run_op("illegal", 3'b111, 1'b0, 8'd0, 1'b0, 1'b1, 2);
        load(8'd2, 8'd2);      run_op("legal_after", 3'b000, 1'b0, 8'd4, 1'b0, 1'b0, 2);

        // store_a with start: load wins, nothing launched.
        store_a = 1'b1; alu_data = 8'd9; opcode_value = 3'b000; start = 1'b1;
        step();
        store_a = 1'b0; start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy || alu_done) cnt++;
            step();
        end
        check("store_start.idle", cnt, 0);
        store_b = 1'b1; alu_data = 8'd1; step(); store_b = 1'b0;
        run_op("store_start.a", 3'b000, 1'b0, 8'd10, 1'b0, 1'b0, 2);

        // start pulses while busy are ignored.
        load(8'd3, 8'd5);
        opcode_value = 3'b110; start = 1'b1; step(); start = 1'b0;
        step();
        opcode_value = 3'b000; start = 1'b1; step(); start = 1'b0;
        step(); step();
        start = 1'b1; step(); start = 1'b0;
        cnt = 0; seen = '0;
        for (int i = 0; i < 20; i++) begin
            if (alu_done) begin cnt++; seen = result; end
            step();
        end
        check("busy_start.done_count", cnt, 1);
        check("busy_start.result", seen, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
